// File: rtl/alu_ctl_seq_if.sv
// Request/response bundle between the main control unit and the ALU control sequencer.
interface alu_ctl_seq_if #(
  parameter int OP_W   = 4,
  parameter int FUNC_W = 6,
  parameter int CTL_W  = 5
);
  logic              valid_in;
  logic [OP_W-1:0]   alu_op;
  logic [FUNC_W-1:0] func_code;
  logic              ready;
  logic [CTL_W-1:0]  alu_ctl;
  logic              jr;
  logic              illegal;
  logic              valid_out;
  logic              busy;

  modport master (
    output valid_in, alu_op, func_code,
    input  ready, alu_ctl, jr, illegal, valid_out, busy
  );

  modport slave (
    input  valid_in, alu_op, func_code,
    output ready, alu_ctl, jr, illegal, valid_out, busy
  );
endinterface

// File: rtl/alu_ctl_seq.sv
// Registered ALU control decoder that holds the control word for multi-cycle ops.
// Define ALUCTL_DIV_EN to add the divide opcodes.
module alu_ctl_seq #(
    parameter int OP_W       = 4,
    parameter int FUNC_W     = 6,
    parameter int CTL_W      = 5,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic         clk,
    input  logic         reset,
    alu_ctl_seq_if.slave bus
);

    // Sized for both op lengths so either build shares one counter layout.
    localparam int MAXC  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CTL_W-1:0] dec_ctl;
    logic             dec_jr;
    logic             dec_ill;
    int               dec_n;
    logic             accept;

    assign bus.ready = (state == IDLE);
    assign accept    = bus.valid_in & bus.ready;

    always_comb begin
        dec_ctl = '0;
        dec_jr  = 1'b0;
        dec_ill = 1'b0;
        dec_n   = 1;
        if (int'(bus.alu_op) == 2) begin
            case (int'(bus.func_code))
                32: dec_ctl = CTL_W'(0);
                34: dec_ctl = CTL_W'(1);
                56: dec_ctl = CTL_W'(5);
                57: dec_ctl = CTL_W'(7);
                58: dec_ctl = CTL_W'(6);
                37: begin dec_ctl = CTL_W'(4); dec_n = MUL_CYCLES; end
                7:  dec_ctl = CTL_W'(3);
                6:  dec_ctl = CTL_W'(2);
                52: dec_ctl = CTL_W'(8);
                54: dec_ctl = CTL_W'(9);
                51: dec_ctl = CTL_W'(10);
                3:  dec_ctl = CTL_W'(11);
                1:  begin dec_ctl = CTL_W'(20); dec_jr = 1'b1; end
`ifdef ALUCTL_DIV_EN
                38: begin dec_ctl = CTL_W'(16); dec_n = DIV_CYCLES; end
`endif
                default: dec_ill = 1'b1;
            endcase
        end else begin
            case (int'(bus.alu_op))
                0:  dec_ctl = CTL_W'(0);
                1:  dec_ctl = CTL_W'(1);
                3:  dec_ctl = CTL_W'(5);
                4:  begin dec_ctl = CTL_W'(4); dec_n = MUL_CYCLES; end
                5:  dec_ctl = CTL_W'(7);
                6:  dec_ctl = CTL_W'(6);
                7:  dec_ctl = CTL_W'(10);
                8:  dec_ctl = CTL_W'(12);
                9:  dec_ctl = CTL_W'(13);
                10: dec_ctl = CTL_W'(14);
                11: dec_ctl = CTL_W'(15);
                12: dec_ctl = CTL_W'(11);
`ifdef ALUCTL_DIV_EN
                13: begin dec_ctl = CTL_W'(16); dec_n = DIV_CYCLES; end
`endif
                default: dec_ill = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.alu_ctl   <= '0;
            bus.jr        <= 1'b0;
            bus.illegal   <= 1'b0;
            bus.valid_out <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.alu_ctl <= dec_ctl;
                        bus.jr      <= dec_jr;
                        bus.illegal <= dec_ill;
                        if (dec_n > 1) begin
                            // counter holds remaining HOLD cycles after this one
                            state    <= HOLD;
                            bus.busy <= 1'b1;
                            cnt      <= CNT_W'(dec_n - 2);
                        end else begin
                            bus.valid_out <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state         <= IDLE;
                        bus.busy      <= 1'b0;
                        bus.valid_out <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctl_seq.sv
// Directed self-checking bench for alu_ctl_seq (MUL_CYCLES=4, DIV_CYCLES=8).
module tb_alu_ctl_seq;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    alu_ctl_seq_if #(.OP_W(4), .FUNC_W(6), .CTL_W(5)) bus ();

    alu_ctl_seq #(
        .OP_W(4), .FUNC_W(6), .CTL_W(5), .MUL_CYCLES(4), .DIV_CYCLES(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int op, input int fn);
        bus.valid_in  = v;
        bus.alu_op    = 4'(op);
        bus.func_code = 6'(fn);
    endtask

    // packed observation: {alu_ctl[4:0], jr, illegal, valid_out, busy, ready}
    function automatic logic [9:0] obs();
        return {bus.alu_ctl, bus.jr, bus.illegal, bus.valid_out, bus.busy, bus.ready};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 0, 0);
        #12;
        checks++;
        if (obs() !== 10'b00000_0_0_0_0_1) begin
            errors++;
            $display("FAIL reset_state: got %b want %b", obs(), 10'b00000_0_0_0_0_1);
        end
        @(negedge clk);
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_jr();
        drive(1'b1, 2, 1);
        cyc();
        drive(1'b0, 0, 0);
        checks++;
        if (obs() !== {5'd20, 5'b1_0_1_0_1}) begin
            errors++;
            $display("FAIL jr_decode: got %b want %b", obs(), {5'd20, 5'b1_0_1_0_1});
        end
        cyc();
        checks++;
        if (obs() !== {5'd20, 5'b1_0_0_0_1}) begin
            errors++;
            $display("FAIL jr_hold: got %b want %b", obs(), {5'd20, 5'b1_0_0_0_1});
        end
    endtask

    task automatic test_back_to_back();
        int op[22]  = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 0, 1, 3, 5, 6, 7, 8, 9, 10, 11, 12};
        int fn[22]  = '{32, 34, 56, 57, 58, 7, 6, 52, 54, 51, 3, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        int ctl[22] = '{0, 1, 5, 7, 6, 3, 2, 8, 9, 10, 11, 0, 1, 5, 7, 6, 10, 12, 13, 14, 15, 11};
        logic [9:0] exp;
        for (int i = 0; i < 22; i++) begin
            drive(1'b1, op[i], fn[i]);
            cyc();
            exp = {5'(ctl[i]), 5'b0_0_1_0_1};
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL decode[%0d] op=%0d fn=%0d: got %b want %b", i, op[i], fn[i], obs(), exp);
            end
        end
        drive(1'b0, 0, 0);
        cyc();
    endtask

    task automatic test_mul();
        drive(1'b1, 4, 0);
        cyc();
        drive(1'b1, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if (obs() !== {5'd4, 5'b0_0_0_1_0}) begin
                errors++;
                $display("FAIL mul_busy k+%0d: got %b want %b", i, obs(), {5'd4, 5'b0_0_0_1_0});
            end
            cyc();
        end
        checks++;
        if (obs() !== {5'd4, 5'b0_0_1_0_1}) begin
            errors++;
            $display("FAIL mul_done: got %b want %b", obs(), {5'd4, 5'b0_0_1_0_1});
        end
        cyc();
        drive(1'b0, 0, 0);
        checks++;
        if (obs() !== {5'd0, 5'b0_0_1_0_1}) begin
            errors++;
            $display("FAIL mul_next: got %b want %b", obs(), {5'd0, 5'b0_0_1_0_1});
        end
        cyc();
        checks++;
        if (obs() !== {5'd0, 5'b0_0_0_0_1}) begin
            errors++;
            $display("FAIL mul_quiet: got %b want %b", obs(), {5'd0, 5'b0_0_0_0_1});
        end
        // R-type multiply
        drive(1'b1, 2, 37);
        cyc();
        drive(1'b0, 0, 0);
        checks++;
        if (obs() !== {5'd4, 5'b0_0_0_1_0}) begin
            errors++;
            $display("FAIL mul_rtype: got %b want %b", obs(), {5'd4, 5'b0_0_0_1_0});
        end
        repeat (4) cyc();
    endtask

    task automatic test_illegal();
        drive(1'b1, 15, 0);
        cyc();
        checks++;
        if (obs() !== {5'd0, 5'b0_1_1_0_1}) begin
            errors++;
            $display("FAIL illegal_op15: got %b want %b", obs(), {5'd0, 5'b0_1_1_0_1});
        end
        drive(1'b1, 1, 0);
        cyc();
        checks++;
        if (obs() !== {5'd1, 5'b0_0_1_0_1}) begin
            errors++;
            $display("FAIL illegal_clear: got %b want %b", obs(), {5'd1, 5'b0_0_1_0_1});
        end
        drive(1'b1, 2, 63);
        cyc();
        drive(1'b0, 0, 0);
        checks++;
        if (obs() !== {5'd0, 5'b0_1_1_0_1}) begin
            errors++;
            $display("FAIL illegal_func63: got %b want %b", obs(), {5'd0, 5'b0_1_1_0_1});
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        int vo;
        drive(1'b1, 4, 0);
        cyc();
        drive(1'b0, 0, 0);
        cyc();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (obs() !== 10'b00000_0_0_0_0_1) begin
            errors++;
            $display("FAIL reset_async: got %b want %b", obs(), 10'b00000_0_0_0_0_1);
        end
        #1;
        reset = 1'b0;
        vo = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (bus.valid_out !== 1'b0 || bus.busy !== 1'b0) vo++;
        end
        checks++;
        if (vo !== 0) begin
            errors++;
            $display("FAIL reset_discard: got %0d active cycles want 0", vo);
        end
        drive(1'b1, 1, 0);
        cyc();
        drive(1'b0, 0, 0);
        checks++;
        if (obs() !== {5'd1, 5'b0_0_1_0_1}) begin
            errors++;
            $display("FAIL reset_fresh: got %b want %b", obs(), {5'd1, 5'b0_0_1_0_1});
        end
        cyc();
    endtask

    task automatic test_div();
        int op[2] = '{2, 13};
        int fn[2] = '{38, 0};
        for (int t = 0; t < 2; t++) begin
            drive(1'b1, op[t], fn[t]);
            cyc();
            drive(1'b0, 0, 0);
`ifdef ALUCTL_DIV_EN
            for (int i = 1; i <= 7; i++) begin
                checks++;
                if (obs() !== {5'd16, 5'b0_0_0_1_0}) begin
                    errors++;
                    $display("FAIL div_busy[%0d] k+%0d: got %b want %b", t, i, obs(), {5'd16, 5'b0_0_0_1_0});
                end
                cyc();
            end
            checks++;
            if (obs() !== {5'd16, 5'b0_0_1_0_1}) begin
                errors++;
                $display("FAIL div_done[%0d]: got %b want %b", t, obs(), {5'd16, 5'b0_0_1_0_1});
            end
`else
            checks++;
            if (obs() !== {5'd0, 5'b0_1_1_0_1}) begin
                errors++;
                $display("FAIL div_disabled[%0d]: got %b want %b", t, obs(), {5'd0, 5'b0_1_1_0_1});
            end
`endif
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_jr();
        test_back_to_back();
        test_mul();
        test_illegal();
        test_reset_mid();
        test_div();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
